memory_lsu: RTL and testbench
=============================

MEMORY_LSU -- requirements
Module: memory_lsu

Interface
REQ-001 Parameters:
- XLEN, default 32, datapath width; legal values are 32 and 64.
- REGW, default 5, destination-register index width.
- TIMEOUT, default 255, maximum wait cycles for mem_done before abort; legal range 1..65535.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, reset; asynchronous, active-high.
- in_valid, in, 1, instruction present from execute.
- addr, in, XLEN, effective address (ALU result).
- data_in, in, XLEN, store data, right-aligned.
- funct3, in, 3, access size/sign: 000 LB, 001 LH, 010 LW, 011 LD (XLEN=64 only), 100 LBU, 101 LHU, 110 LWU (XLEN=64 only).
- MemRead, in, 1, load.
- MemWrite, in, 1, store.
- in_MemToReg, in_RegWrite, in_PCSrc, in, 1 each, passthrough controls.
- in_RegDest, in, REGW, passthrough destination register.
- in_BranchTarget, in, XLEN, passthrough branch target.
- out_valid, out, 1, one-cycle result-valid pulse.
- data_out, out, XLEN, aligned and extended load data.
- out_AluResult, out, XLEN, registered addr.
- out_MemToReg, out_RegWrite, out_PCSrc, out, 1 each, registered passthrough controls.
- out_RegDest, out, REGW, registered passthrough destination register.
- out_BranchTarget, out, XLEN, registered passthrough branch target.
- stall_pipeline, out, 1, upstream must hold its inputs.
- bus_err, out, 1, timeout flag, valid with out_valid.
- misalign, out, 1, misalignment flag, valid with out_valid.
- mem_addr, out, XLEN, word-aligned RAM address.
- mem_req, out, 1, request, level-held until done.
- mem_we, out, 1, write request.
- mem_wstrb, out, XLEN/8, byte-lane enables.
- mem_wdata, out, XLEN, lane-shifted store data.
- mem_rdata, in, XLEN, RAM read data.
- mem_done, in, 1, RAM completion, one cycle.

Function
REQ-003 The FSM SHALL have states IDLE, WAIT, and DONE.
REQ-004 In IDLE with in_valid=1 and neither MemRead nor MemWrite, the block SHALL register all passthrough signals and addr, then pulse out_valid on the next cycle with no stall (latency 1).
REQ-005 In IDLE with in_valid=1 and MemRead or MemWrite, the block SHALL register request fields, drive mem_req=1 from the next cycle, and enter WAIT.
REQ-006 In WAIT, mem_addr, mem_we, mem_wstrb, and mem_wdata SHALL remain constant until mem_done.
REQ-007 stall_pipeline SHALL equal (state==WAIT) OR (state==IDLE AND in_valid AND (MemRead OR MemWrite)); it is combinational.
REQ-008 When mem_done=1 in WAIT, the block SHALL capture the loaded value, deassert mem_req on the following cycle, enter DONE, and pulse out_valid for one cycle while in DONE.
REQ-009 DONE SHALL return to IDLE unconditionally; the block SHALL accept no new instruction while in DONE.
REQ-010 mem_addr SHALL equal addr with its low log2(XLEN/8) bits cleared.
REQ-011 The byte offset SHALL select lanes. Store lanes: mem_wdata = data_in shifted left by 8*offset; mem_wstrb = size mask (1, 3, 15, or 255 bytes) shifted by offset, truncated to XLEN/8 bits.
REQ-012 For loads, data_out SHALL equal mem_rdata shifted right by 8*offset, truncated to the access size, then sign-extended (funct3[2]=0) or zero-extended (funct3[2]=1) to XLEN.
REQ-013 The wait counter SHALL count cycles spent in WAIT. On reaching TIMEOUT without mem_done, the block SHALL drop mem_req, set bus_err=1, force out_RegWrite=0, and enter DONE.
REQ-014 When mem_done and the timeout occur in the same cycle, mem_done SHALL win and bus_err SHALL be 0.
REQ-015 A mem_done received outside WAIT SHALL be ignored.
REQ-016 funct3 011 or 110 with XLEN=32 SHALL be treated as 010.

Reset
REQ-017 While rst is high, the block SHALL force state IDLE, counter 0, and every registered output to 0, including mem_req, mem_we, mem_wstrb, out_valid, bus_err, and misalign.
REQ-018 Reset asserted during WAIT SHALL abort the access immediately; mem_req SHALL be 0 in the same cycle and no out_valid SHALL follow.

Configuration
REQ-019 Macro MEMORY_LSU_MISALIGN_TRAP_EN:
- Defined: an access with offset not a multiple of its size SHALL issue no mem_req and go straight to DONE with misalign=1 and out_RegWrite=0.
- Undefined: misalign SHALL be tied 0, and lanes that overflow the word SHALL be discarded per REQ-011/012.

Verification
REQ-020 XLEN=32: SW addr=0x104, data_in=0xDEADBEEF, mem_done after 3 cycles -> mem_addr=0x104, mem_wstrb=1111, stall high for 4 cycles, out_valid pulse.
REQ-021 LB addr=0x103, mem_rdata=0x80FF_0000 -> data_out=0xFFFFFF80. LBU at the same address -> data_out=0x00000080.
REQ-022 SH addr=0x102, data_in=0x1234 -> mem_wstrb=1100, mem_wdata=0x12340000.
REQ-023 TIMEOUT=4, load with mem_done never asserted -> mem_req high for exactly 4 cycles, then bus_err=1, out_RegWrite=0, out_valid pulse.
REQ-024 With the macro defined, LW addr=0x101 -> mem_req stays 0, misalign=1 at out_valid. With the macro undefined, the same access issues mem_req with mem_addr=0x100.
REQ-025 rst pulsed in WAIT -> mem_req=0 during reset, no out_valid afterwards. A following ALU op (RegDest=7) -> out_valid one cycle later with out_RegDest=7.

Source files
------------

// File: rtl/memory_lsu.sv
// Load/store unit between execute and a single-port RAM: lane steering, load
// extension and a bounded wait for mem_done. Option: MEMORY_LSU_MISALIGN_TRAP_EN.
module memory_lsu #(
  parameter int XLEN    = 32,
  parameter int REGW    = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   data_in,
  input  logic [2:0]        funct3,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              in_MemToReg,
  input  logic              in_RegWrite,
  input  logic              in_PCSrc,
  input  logic [REGW-1:0]   in_RegDest,
  input  logic [XLEN-1:0]   in_BranchTarget,
  output logic              out_valid,
  output logic [XLEN-1:0]   data_out,
  output logic [XLEN-1:0]   out_AluResult,
  output logic              out_MemToReg,
  output logic              out_RegWrite,
  output logic              out_PCSrc,
  output logic [REGW-1:0]   out_RegDest,
  output logic [XLEN-1:0]   out_BranchTarget,
  output logic              stall_pipeline,
  output logic              bus_err,
  output logic              misalign,
  output logic [XLEN-1:0]   mem_addr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_wstrb,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_done
);
  localparam int BYTES = XLEN / 8;
  localparam int OFFW  = $clog2(BYTES);
`ifdef MEMORY_LSU_MISALIGN_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   dout_q, dout_d;
  logic [XLEN-1:0]   alu_q, alu_d;
  logic              memToReg_q, memToReg_d;
  logic              regWrite_q, regWrite_d;
  logic              pcSrc_q, pcSrc_d;
  logic [REGW-1:0]   regDest_q, regDest_d;
  logic [XLEN-1:0]   btgt_q, btgt_d;
  logic              busErr_q, busErr_d;
  logic              mis_q, mis_d;
  logic [XLEN-1:0]   maddr_q, maddr_d;
  logic              mreq_q, mreq_d;
  logic              mwe_q, mwe_d;
  logic [BYTES-1:0]  mstrb_q, mstrb_d;
  logic [XLEN-1:0]   mwdata_q, mwdata_d;
  logic [2:0]        f3_q, f3_d;
  logic [OFFW-1:0]   off_q, off_d;

  // On a 32-bit datapath the doubleword and LWU encodings collapse onto LW.
  function automatic logic [2:0] remapF3(input logic [2:0] f);
    if (XLEN == 32 && (f == 3'b011 || f == 3'b110)) return 3'b010;
    return f;
  endfunction

  function automatic logic [3:0] sizeBytes(input logic [2:0] f);
    case (f[1:0])
      2'd0:    return 4'd1;
      2'd1:    return 4'd2;
      2'd2:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  logic [2:0]      f3In;
  logic [3:0]      nbIn;
  logic [OFFW-1:0] offIn;
  logic            misIn;
  logic [7:0]      byteMask;
  logic [15:0]     strbWide;
  logic [XLEN-1:0] wdataIn;

  always_comb begin
    f3In     = remapF3(funct3);
    nbIn     = sizeBytes(f3In);
    offIn    = addr[OFFW-1:0];
    misIn    = (offIn & OFFW'(nbIn - 4'd1)) != '0;
    byteMask = 8'((16'd1 << nbIn) - 16'd1);
    strbWide = 16'(byteMask) << offIn;
    wdataIn  = data_in << {offIn, 3'b000};
  end

  logic [XLEN-1:0] rdShift;
  logic [XLEN-1:0] loadVal;
  logic [3:0]      nbQ;
  logic            signBit;
  int              nbits;

  // Lanes shifted past the top of the word simply fall off; extension fills the rest.
  always_comb begin
    rdShift = mem_rdata >> {off_q, 3'b000};
    nbQ     = sizeBytes(f3_q);
    nbits   = 8 * int'(nbQ);
    case (nbQ)
      4'd1:    signBit = rdShift[7];
      4'd2:    signBit = rdShift[15];
      4'd4:    signBit = rdShift[31];
      default: signBit = rdShift[XLEN-1];
    endcase
    signBit = signBit & ~f3_q[2];
    loadVal = '0;
    for (int i = 0; i < XLEN; i++)
      loadVal[i] = (i < nbits) ? rdShift[i] : signBit;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    valid_d    = 1'b0;
    dout_d     = dout_q;
    alu_d      = alu_q;
    memToReg_d = memToReg_q;
    regWrite_d = regWrite_q;
    pcSrc_d    = pcSrc_q;
    regDest_d  = regDest_q;
    btgt_d     = btgt_q;
    busErr_d   = busErr_q;
    mis_d      = mis_q;
    maddr_d    = maddr_q;
    mreq_d     = mreq_q;
    mwe_d      = mwe_q;
    mstrb_d    = mstrb_q;
    mwdata_d   = mwdata_q;
    f3_d       = f3_q;
    off_d      = off_q;
    case (state_q)
      IDLE: begin
        busErr_d = 1'b0;
        mis_d    = 1'b0;
        if (in_valid) begin
          alu_d      = addr;
          memToReg_d = in_MemToReg;
          regWrite_d = in_RegWrite;
          pcSrc_d    = in_PCSrc;
          regDest_d  = in_RegDest;
          btgt_d     = in_BranchTarget;
          dout_d     = '0;
          if (MemRead || MemWrite) begin
            f3_d     = f3In;
            off_d    = offIn;
            maddr_d  = {addr[XLEN-1:OFFW], {OFFW{1'b0}}};
            mwe_d    = MemWrite;
            mstrb_d  = MemWrite ? strbWide[BYTES-1:0] : '0;
            mwdata_d = MemWrite ? wdataIn : '0;
            cnt_d    = '0;
            if (TrapEn && misIn) begin
              mis_d      = 1'b1;
              regWrite_d = 1'b0;
              valid_d    = 1'b1;
              state_d    = DONE;
            end else begin
              mreq_d  = 1'b1;
              state_d = WAIT;
            end
          end else begin
            valid_d = 1'b1;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 16'd1;
        // A completion in the final allowed cycle still counts as success.
        if (mem_done) begin
          dout_d  = mwe_q ? '0 : loadVal;
          mreq_d  = 1'b0;
          mwe_d   = 1'b0;
          mstrb_d = '0;
          valid_d = 1'b1;
          state_d = DONE;
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
          busErr_d   = 1'b1;
          regWrite_d = 1'b0;
          mreq_d     = 1'b0;
          mwe_d      = 1'b0;
          mstrb_d    = '0;
          valid_d    = 1'b1;
          state_d    = DONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      dout_q     <= '0;
      alu_q      <= '0;
      memToReg_q <= 1'b0;
      regWrite_q <= 1'b0;
      pcSrc_q    <= 1'b0;
      regDest_q  <= '0;
      btgt_q     <= '0;
      busErr_q   <= 1'b0;
      mis_q      <= 1'b0;
      maddr_q    <= '0;
      mreq_q     <= 1'b0;
      mwe_q      <= 1'b0;
      mstrb_q    <= '0;
      mwdata_q   <= '0;
      f3_q       <= '0;
      off_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      dout_q     <= dout_d;
      alu_q      <= alu_d;
      memToReg_q <= memToReg_d;
      regWrite_q <= regWrite_d;
      pcSrc_q    <= pcSrc_d;
      regDest_q  <= regDest_d;
      btgt_q     <= btgt_d;
      busErr_q   <= busErr_d;
      mis_q      <= mis_d;
      maddr_q    <= maddr_d;
      mreq_q     <= mreq_d;
      mwe_q      <= mwe_d;
      mstrb_q    <= mstrb_d;
      mwdata_q   <= mwdata_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
    end
  end

  assign stall_pipeline   = (state_q == WAIT) ||
                            (state_q == IDLE && in_valid && (MemRead || MemWrite));
  assign out_valid        = valid_q;
  assign data_out         = dout_q;
  assign out_AluResult    = alu_q;
  assign out_MemToReg     = memToReg_q;
  assign out_RegWrite     = regWrite_q;
  assign out_PCSrc        = pcSrc_q;
  assign out_RegDest      = regDest_q;
  assign out_BranchTarget = btgt_q;
  assign bus_err          = busErr_q;
  assign misalign         = mis_q;
  assign mem_addr         = maddr_q;
  assign mem_req          = mreq_q;
  assign mem_we           = mwe_q;
  assign mem_wstrb        = mstrb_q;
  assign mem_wdata        = mwdata_q;

endmodule

// File: tb/tb_memory_lsu.sv
// Self-checking bench for memory_lsu (XLEN=32, TIMEOUT=4): transaction-level model
// feeding an expected-result queue, checked by one negedge compare process.
module tb_memory_lsu;
  localparam int XLEN    = 32;
  localparam int REGW    = 5;
  localparam int TIMEOUT = 4;
`ifdef MEMORY_LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, MemRead, MemWrite;
  logic [31:0]     addr, data_in, in_BranchTarget, mem_rdata;
  logic [2:0]      funct3;
  logic            in_MemToReg, in_RegWrite, in_PCSrc, mem_done;
  logic [4:0]      in_RegDest;
  logic            out_valid, out_MemToReg, out_RegWrite, out_PCSrc;
  logic [31:0]     data_out, out_AluResult, out_BranchTarget, mem_addr, mem_wdata;
  logic [4:0]      out_RegDest;
  logic            stall_pipeline, bus_err, misalign, mem_req, mem_we;
  logic [3:0]      mem_wstrb;

  always #5 clk = ~clk;

  memory_lsu #(.XLEN(XLEN), .REGW(REGW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .addr(addr), .data_in(data_in),
    .funct3(funct3), .MemRead(MemRead), .MemWrite(MemWrite),
    .in_MemToReg(in_MemToReg), .in_RegWrite(in_RegWrite), .in_PCSrc(in_PCSrc),
    .in_RegDest(in_RegDest), .in_BranchTarget(in_BranchTarget),
    .out_valid(out_valid), .data_out(data_out), .out_AluResult(out_AluResult),
    .out_MemToReg(out_MemToReg), .out_RegWrite(out_RegWrite), .out_PCSrc(out_PCSrc),
    .out_RegDest(out_RegDest), .out_BranchTarget(out_BranchTarget),
    .stall_pipeline(stall_pipeline), .bus_err(bus_err), .misalign(misalign),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done)
  );

  typedef struct {
    logic [31:0] dataOut;
    logic        checkData;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        regWrite;
    logic        memToReg;
    logic        pcSrc;
    logic [31:0] btgt;
    logic        busErr;
    logic        mis;
  } exp_t;

  exp_t        expQ[$];
  exp_t        cur;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] expAddr, expWdata;
  logic [3:0]  expStrb;
  logic        expWe;
  int          obsStall, obsReq;
  logic [31:0] obsAddr, obsWdata, obsData;
  logic [3:0]  obsStrb;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic int bytesOf(input logic [2:0] f);
    case (f[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  // Plain arithmetic view of a load: shift, mask to size, extend.
  function automatic logic [31:0] modelLoad(input logic [2:0] f, input int off, input logic [31:0] rdata);
    int          nb   = bytesOf(f);
    logic [63:0] mask = (64'd1 << (8 * nb)) - 64'd1;
    logic [63:0] v    = ({32'd0, rdata} >> (8 * off)) & mask;
    if (!f[2] && v[8 * nb - 1]) v = v | ~mask;
    return v[31:0];
  endfunction

  // kind: 0 ALU op, 1 load, 2 store. doneAfter: WAIT cycle carrying mem_done (<1 = never).
  task automatic applyStimulus(input int kind, input logic [31:0] a, input logic [31:0] d,
                               input logic [2:0] f3, input int doneAfter,
                               input logic [31:0] rdata, input logic [4:0] rd);
    int   off   = int'(a[1:0]);
    int   nb    = bytesOf(f3);
    bit   trap  = TRAP && (kind != 0) && ((off % nb) != 0);
    bit   err   = (kind != 0) && !trap && (doneAfter < 1 || doneAfter > TIMEOUT);
    bit   last  = 1'b0;
    exp_t e;
    e.alu       = a;
    e.rd        = rd;
    e.memToReg  = (kind == 1);
    e.pcSrc     = rd[0];
    e.btgt      = a + 32'h1000;
    e.busErr    = err;
    e.mis       = trap;
    e.regWrite  = (kind != 2) && !err && !trap;
    e.checkData = (kind == 1) && !err && !trap;
    e.dataOut   = modelLoad(f3, off, rdata);
    expQ.push_back(e);
    expAddr  = a & 32'hFFFF_FFFC;
    expWe    = (kind == 2);
    expStrb  = 4'((((32'd1 << nb) - 32'd1) << off) & 32'hF);
    expWdata = d << (8 * off);
    in_valid = 1'b1; addr = a; data_in = d; funct3 = f3;
    MemRead = (kind == 1); MemWrite = (kind == 2);
    in_MemToReg = (kind == 1); in_RegWrite = (kind != 2); in_PCSrc = rd[0];
    in_RegDest = rd; in_BranchTarget = a + 32'h1000;
    obsStall = 0; obsReq = 0; obsAddr = 'x; obsStrb = 'x; obsWdata = 'x; obsData = 'x;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (stall_pipeline) obsStall++;
      if (mem_req) begin
        obsReq++;
        if (obsReq == 1) begin obsAddr = mem_addr; obsStrb = mem_wstrb; obsWdata = mem_wdata; end
        if (obsReq == doneAfter) begin mem_done = 1'b1; mem_rdata = rdata; end
      end
      if (out_valid) obsData = data_out;
      last = !stall_pipeline;
      @(posedge clk); #1;
      mem_done = 1'b0;
      if (last) break;
    end
    in_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    if (!last) begin
      tests++; fails++;
      $display("[TB] FAIL handshake_timeout: got stall still high, expected release within 40 cycles");
    end
  endtask

  // Compare process: request fields while mem_req is up, results on every out_valid.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req) begin
        checkOutput("req_addr", mem_addr, expAddr);
        checkOutput("req_we", mem_we, expWe);
        if (expWe) begin
          checkOutput("req_wstrb", mem_wstrb, expStrb);
          checkOutput("req_wdata", mem_wdata, expWdata);
        end
      end
      if (out_valid) begin
        if (expQ.size() == 0) begin
          tests++; fails++;
          $display("[TB] FAIL unexpected_out_valid: got 1, expected 0");
        end else begin
          cur = expQ.pop_front();
          if (cur.checkData) checkOutput("data_out", data_out, cur.dataOut);
          checkOutput("alu_result", out_AluResult, cur.alu);
          checkOutput("reg_dest", out_RegDest, cur.rd);
          checkOutput("reg_write", out_RegWrite, cur.regWrite);
          checkOutput("mem_to_reg", out_MemToReg, cur.memToReg);
          checkOutput("pc_src", out_PCSrc, cur.pcSrc);
          checkOutput("branch_target", out_BranchTarget, cur.btgt);
          checkOutput("bus_err", bus_err, cur.busErr);
          checkOutput("misalign", misalign, cur.mis);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200us");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sawValid;
    rst = 1'b1; in_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; addr = '0; data_in = '0;
    funct3 = '0; in_MemToReg = 1'b0; in_RegWrite = 1'b0; in_PCSrc = 1'b0; in_RegDest = '0;
    in_BranchTarget = '0; mem_rdata = '0; mem_done = 1'b0;
    expAddr = '0; expWe = 1'b0; expStrb = '0; expWdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_wstrb", mem_wstrb, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_bus_err", bus_err, 0);
    checkOutput("rst_misalign", misalign, 0);
    checkOutput("rst_stall", stall_pipeline, 0);
    @(posedge clk); #1 rst = 1'b0;

    applyStimulus(0, 32'h0000_0055, 32'h0, 3'b000, 0, 32'h0, 5'd3);
    checkOutput("alu_latency_valid", out_valid, 1);
    checkOutput("alu_stall_cycles", obsStall, 0);

    applyStimulus(2, 32'h0000_0104, 32'hDEAD_BEEF, 3'b010, 3, 32'h0, 5'd0);
    checkOutput("sw_stall_cycles", obsStall, 4);
    checkOutput("sw_mem_addr", obsAddr, 32'h104);
    checkOutput("sw_wstrb", obsStrb, 4'b1111);
    checkOutput("sw_wdata", obsWdata, 32'hDEAD_BEEF);

    applyStimulus(1, 32'h0000_0103, 32'h0, 3'b000, 1, 32'h80FF_0000, 5'd5);
    checkOutput("lb_data", obsData, 32'hFFFF_FF80);
    applyStimulus(1, 32'h0000_0103, 32'h0, 3'b100, 2, 32'h80FF_0000, 5'd6);
    checkOutput("lbu_data", obsData, 32'h0000_0080);

    applyStimulus(2, 32'h0000_0102, 32'h0000_1234, 3'b001, 1, 32'h0, 5'd0);
    checkOutput("sh_wstrb", obsStrb, 4'b1100);
    checkOutput("sh_wdata", obsWdata, 32'h1234_0000);

    applyStimulus(2, 32'h0000_0107, 32'h0000_00AB, 3'b000, 2, 32'h0, 5'd0);
    checkOutput("sb_wstrb", obsStrb, 4'b1000);
    applyStimulus(1, 32'h0000_0106, 32'h0, 3'b001, 1, 32'h8001_0000, 5'd9);
    checkOutput("lh_data", obsData, 32'hFFFF_8001);
    applyStimulus(1, 32'h0000_0102, 32'h0, 3'b101, 1, 32'hFFFF_1234, 5'd10);
    checkOutput("lhu_data", obsData, 32'h0000_FFFF);
    applyStimulus(1, 32'h0000_0108, 32'h0, 3'b011, 1, 32'h89AB_CDEF, 5'd11);
    checkOutput("ld_as_lw_data", obsData, 32'h89AB_CDEF);

    applyStimulus(1, 32'h0000_0200, 32'h0, 3'b010, -1, 32'h0, 5'd12);
    checkOutput("timeout_req_cycles", obsReq, TIMEOUT);
    checkOutput("timeout_stall_cycles", obsStall, TIMEOUT + 1);
    applyStimulus(1, 32'h0000_0204, 32'h0, 3'b010, TIMEOUT, 32'h5A5A_0001, 5'd13);
    checkOutput("tie_done_wins_data", obsData, 32'h5A5A_0001);

    applyStimulus(1, 32'h0000_0101, 32'h0, 3'b010, 1, 32'h1122_3344, 5'd14);
    if (TRAP) begin
      checkOutput("trap_no_req", obsReq, 0);
    end else begin
      checkOutput("lw_unaligned_addr", obsAddr, 32'h100);
      checkOutput("lw_unaligned_data", obsData, 32'h0011_2233);
    end
    applyStimulus(2, 32'h0000_0103, 32'h0000_BEEF, 3'b001, 1, 32'h0, 5'd0);
    applyStimulus(1, 32'h0000_0103, 32'h0, 3'b001, 1, 32'hAA00_0000, 5'd15);

    mem_done = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1 mem_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 checkOutput("stray_done_no_req", mem_req, 0);

    expAddr = 32'h300; expWe = 1'b0;
    in_valid = 1'b1; MemRead = 1'b1; addr = 32'h300; funct3 = 3'b010; in_RegDest = 5'd9;
    @(posedge clk); #1 in_valid = 1'b0; MemRead = 1'b0;
    @(posedge clk); #1;
    checkOutput("pre_reset_req", mem_req, 1);
    #2 rst = 1'b1;
    #1 checkOutput("reset_drops_req", mem_req, 0);
    checkOutput("reset_drops_stall", stall_pipeline, 0);
    @(posedge clk); #1 rst = 1'b0;
    sawValid = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) sawValid++;
    end
    checkOutput("no_valid_after_reset", sawValid, 0);
    @(posedge clk); #1;
    applyStimulus(0, 32'h0000_0777, 32'h0, 3'b000, 0, 32'h0, 5'd7);
    checkOutput("post_reset_alu_valid", out_valid, 1);
    checkOutput("post_reset_alu_rd", out_RegDest, 7);

    repeat (3) @(negedge clk);
    checkOutput("queue_drained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
